ttt_input_conditioner: RTL
==========================

Name: ttt_input_conditioner

Overview:
- Front-end stage that feeds the tic-tac-toe game core (tttg).
- Takes raw, bouncing, asynchronous board switches (9 cell buttons plus PLAY and PC) and synchronises and debounces them.
- Produces a clean held one-hot `button` selection and single-cycle `play`/`pc` strobes, which the core consumes directly.
- Rejects invalid multi-cell presses so the core only ever sees a legal one-hot cell.

Parameters:
- DEBOUNCE_CYCLES, default 16: consecutive stable cycles required before a debounced level changes.
- SYNC_STAGES, default 2: synchroniser flops per raw input (minimum 2).
- CNT_W, default 5: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- btn_raw  in  9  raw cell switches, bit0 = cell1 … bit8 = cell9, active-high
- play_raw  in  1  raw PLAY switch
- pc_raw  in  1  raw PC-move switch
- button  out  9  latched one-hot cell selection to core (0 = none)
- play  out  1  one-cycle player-move strobe
- pc  out  1  one-cycle computer-move strobe
- sel_valid  out  1  high while `button` holds a selection

Behaviour:
- Reset (async assert, sync-free deassert) clears all synchroniser flops, debounced levels and counters to 0. Reset values: button = 0, play = 0, pc = 0, sel_valid = 0.
- Synchroniser: each of the 11 inputs passes through SYNC_STAGES flops.
- Debounce, per input:
  - Counter increments while the synchronised value differs from the debounced level.
  - Counter clears to 0 whenever they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES is invisible.
- Rising edge = debounced level 0 -> 1, registered. Latency from a clean raw edge to its output effect is SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles (19 with defaults).
- Cell selection:
  - Triggered on any cell rising edge.
  - If the debounced cell vector is exactly one-hot: button <= vector, sel_valid <= 1. A new selection replaces any previous one.
  - If two or more cells are debounced-high: no update (rejected).
  - Cell falling edges are ignored; the selection stays latched after release.
- Command FSM:
  - States: IDLE, PLAY_OUT, PC_OUT, PC_PEND.
  - IDLE + PLAY rise + sel_valid -> PLAY_OUT.
  - IDLE + PLAY rise + !sel_valid -> PLAY is ignored and the FSM stays in IDLE.
  - IDLE + PC rise -> PC_OUT.
  - PLAY_OUT: play = 1 for exactly one cycle with `button` stable. On exit, button <= 0 and sel_valid <= 0. Next state is IDLE.
  - PC_OUT: pc = 1 for exactly one cycle. `button` is untouched. Next state is IDLE.
  - PLAY and PC rising in the same cycle (PLAY valid): PLAY_OUT first, then PC_PEND, then PC_OUT. This gives a pc strobe 2 cycles after play.
  - PLAY and PC rising in the same cycle with !sel_valid: PC_OUT only.
- A cell rise arriving during PLAY_OUT is applied after the clear, i.e. the new selection survives.
- play and pc are never high in the same cycle.
- Reset mid-sequence (any state, including PC_PEND) returns to IDLE and drops any pending strobe.

Optional Feature:
- Macro: TTT_MULTI_PRESS_ERR_EN.
- When defined: adds output port `err` (1 bit, reset 0). err pulses high for one cycle on every rejected multi-cell press, and on every PLAY rise ignored for !sel_valid.
- When undefined: no `err` port; rejections are silent. All other behaviour is identical.

Decomposition:
- Package ttt_pkg holds:
  - NUM_CELLS = 9
  - cell_vec_t (9-bit one-hot)
  - the cell-state encoding shared with the game core (2-bit EMPTY/PLAYER/PC)
  - the command FSM state enum
- Sub-module ttt_debounce: synchroniser plus counter for one bit, with outputs level and rise. Instantiated 11 times via generate. The parent holds the selection latch and command FSM.

Test Plan:
- Reset: hold reset 200 ns with raw inputs toggling -> all outputs 0. Release reset -> outputs stay 0 with no spurious strobes.
- Bounce rejection: btn_raw[4] toggled every 3 cycles for 40 cycles, then held 1 -> exactly one selection, button = 9'b000010000, sel_valid = 1. No change from the bounce phase.
- Player move: select cell 9 (btn_raw = 9'b100000000), release, then PLAY press -> play high 1 cycle while button = 9'b100000000. Next cycle button = 0 and sel_valid = 0. pc never asserted.
- Multi-press: btn_raw = 9'b000000011 held -> button unchanged (0), no play on a later PLAY press. With TTT_MULTI_PRESS_ERR_EN, err pulses twice.
- Simultaneous: cell 1 selected, then PLAY and PC raw rising in the same cycle -> play at cycle N, pc at N+2, never overlapping.
- Reset mid-operation: assert reset in the PC_PEND cycle -> no pc strobe. After release the FSM is IDLE and button = 0.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe front end and game core:
// cell vector type, cell-state encoding and command FSM states.
package ttt_pkg;

    localparam int unsigned NUM_CELLS = 9;

    typedef logic [NUM_CELLS-1:0] cell_vec_t;

    typedef enum logic [1:0] {
        CELL_EMPTY  = 2'b00,
        CELL_PLAYER = 2'b01,
        CELL_PC     = 2'b10
    } cell_state_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        PLAY_OUT = 2'b01,
        PC_OUT   = 2'b10,
        PC_PEND  = 2'b11
    } cmd_state_e;

    function automatic logic is_one_hot(input cell_vec_t v);
        return (v != '0) && ((v & (v - cell_vec_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/ttt_debounce.sv
// One-bit synchroniser plus stability-counter debouncer; emits the
// debounced level and a registered one-cycle rise pulse.
module ttt_debounce
    import ttt_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned CNT_W           = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], din};
        cnt_d   = '0;
        level_d = level_q;
        // Counter only runs while the input disagrees with the held level.
        if (sync_out != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        rise_d = level_d & ~level_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/ttt_input_conditioner.sv
// Board-switch front end: debounces 9 cells + PLAY + PC, latches a one-hot
// selection and issues play/pc strobes. TTT_MULTI_PRESS_ERR_EN adds `err`.
module ttt_input_conditioner
    import ttt_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned CNT_W           = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CELLS-1:0] btn_raw,
    input  logic                 play_raw,
    input  logic                 pc_raw,
    output logic [NUM_CELLS-1:0] button,
    output logic                 play,
    output logic                 pc,
    output logic                 sel_valid
`ifdef TTT_MULTI_PRESS_ERR_EN
    ,
    output logic                 err
`endif
);

    localparam int unsigned NUM_IN = NUM_CELLS + 2;

    logic [NUM_IN-1:0] raw_vec;
    logic [NUM_IN-1:0] lvl_vec;
    logic [NUM_IN-1:0] rise_vec;

    cell_vec_t cell_lvl;
    cell_vec_t cell_rise;
    logic      play_rise;
    logic      pc_rise;
    logic      unused_cmd_lvl;

    assign raw_vec = {pc_raw, play_raw, btn_raw};

    for (genvar i = 0; i < NUM_IN; i++) begin : g_db
        ttt_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES),
            .CNT_W           (CNT_W)
        ) u_db (
            .clk   (clk),
            .reset (reset),
            .din   (raw_vec[i]),
            .level (lvl_vec[i]),
            .rise  (rise_vec[i])
        );
    end

    assign cell_lvl       = lvl_vec[NUM_CELLS-1:0];
    assign cell_rise      = rise_vec[NUM_CELLS-1:0];
    assign play_rise      = rise_vec[NUM_CELLS];
    assign pc_rise        = rise_vec[NUM_CELLS+1];
    assign unused_cmd_lvl = &{1'b0, lvl_vec[NUM_IN-1:NUM_CELLS]};

    cmd_state_e state_q, state_d;
    cell_vec_t  button_q, button_d;
    logic       sel_valid_q, sel_valid_d;
    logic       pc_after_q, pc_after_d;

    always_comb begin
        state_d     = state_q;
        button_d    = button_q;
        sel_valid_d = sel_valid_q;
        pc_after_d  = pc_after_q;

        case (state_q)
            IDLE: begin
                if (play_rise && sel_valid_q) begin
                    state_d    = PLAY_OUT;
                    pc_after_d = pc_rise;
                end else if (pc_rise) begin
                    state_d = PC_OUT;
                end
            end
            PLAY_OUT: begin
                button_d    = '0;
                sel_valid_d = 1'b0;
                pc_after_d  = 1'b0;
                state_d     = (pc_after_q || pc_rise) ? PC_PEND : IDLE;
            end
            PC_PEND: state_d = PC_OUT;
            PC_OUT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Evaluated after the PLAY_OUT clear so a concurrent new pick survives.
        if ((cell_rise != '0) && is_one_hot(cell_lvl)) begin
            button_d    = cell_lvl;
            sel_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            button_q    <= '0;
            sel_valid_q <= 1'b0;
            pc_after_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            button_q    <= button_d;
            sel_valid_q <= sel_valid_d;
            pc_after_q  <= pc_after_d;
        end
    end

    assign button    = button_q;
    assign sel_valid = sel_valid_q;
    assign play      = (state_q == PLAY_OUT);
    assign pc        = (state_q == PC_OUT);

`ifdef TTT_MULTI_PRESS_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = ((cell_rise != '0) && !is_one_hot(cell_lvl))
             || ((state_q == IDLE) && play_rise && !sel_valid_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule
